pwm_multichannel: RTL

N-channel PWM generator with one shared period counter. It is the parametrised successor of the single-channel 8-bit PWM.
- Adds programmable period (TOP), edge-aligned or center-aligned mode, and a per-channel duty write port.
- Duty, TOP and mode updates are double-buffered and take effect only at a period boundary, so no glitches occur.
- Drives the scope's test-signal outputs and analog (RC-filtered) reference outputs.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_counter.sv | 60 ++++++
 rtl/pwm_multichannel.sv | 88 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multichannel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Channel-select width; never narrower than one bit.
    function automatic int unsigned ch_sel_width(input int unsigned n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Shared period counter: holds cnt/dir plus active top/mode and flags the boundary cycle.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] TOP_RST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] next_top,
    input  pwm_mode_e        next_mode,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary
);

    logic [WIDTH-1:0] top_q;
    pwm_mode_e        mode_q;
    pwm_dir_e         dir_q;

    always_comb begin
        boundary = 1'b0;
        if (en) begin
            if (top_q == '0)
                boundary = 1'b1;
            else if (mode_q == PWM_EDGE)
                boundary = (cnt == top_q);
            else
                boundary = (cnt == '0) && (dir_q == DIR_DOWN);
        end
    end

    // Every boundary restarts at cnt=0/up: this covers the edge wrap, the
    // centre-mode dwell at zero and the restart required on a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            dir_q  <= DIR_UP;
            top_q  <= TOP_RST;
            mode_q <= PWM_EDGE;
        end else if (boundary) begin
            cnt    <= '0;
            dir_q  <= DIR_UP;
            top_q  <= next_top;
            mode_q <= next_mode;
        end else if (en) begin
            if (mode_q == PWM_EDGE) begin
                cnt <= cnt + WIDTH'(1);
            end else if (dir_q == DIR_UP) begin
                if (cnt == top_q - WIDTH'(1))
                    dir_q <= DIR_DOWN;
                else
                    cnt <= cnt + WIDTH'(1);
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with a shared counter and double-buffered duty/top/mode registers.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned      N_CH    = 4,
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] TOP_RST = '1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              duty_wr,
    input  logic [ch_sel_width(N_CH)-1:0]     duty_ch,
    input  logic [WIDTH-1:0]                  duty_in,
    input  logic                              cfg_wr,
    input  logic [WIDTH-1:0]                  top_in,
    input  logic                              mode_in,
    output logic [N_CH-1:0]                   pwm,
    output logic                              period_end
);

    localparam int unsigned CH_W = ch_sel_width(N_CH);

    logic [WIDTH-1:0] pend_top;
    logic [WIDTH-1:0] top_nxt;
    pwm_mode_e        pend_mode;
    pwm_mode_e        mode_nxt;
    logic [WIDTH-1:0] cnt;
    logic             boundary;

    // Pending values including this cycle's write, so a write in the boundary cycle lands in that load.
    always_comb begin
        top_nxt  = cfg_wr ? top_in : pend_top;
        mode_nxt = cfg_wr ? pwm_mode_e'(mode_in) : pend_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_top   <= TOP_RST;
            pend_mode  <= PWM_EDGE;
            period_end <= 1'b0;
        end else begin
            pend_top   <= top_nxt;
            pend_mode  <= mode_nxt;
            period_end <= boundary;
        end
    end

    pwm_counter #(
        .WIDTH   (WIDTH),
        .TOP_RST (TOP_RST)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .next_top  (top_nxt),
        .next_mode (mode_nxt),
        .cnt       (cnt),
        .boundary  (boundary)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] pend_q;
        logic [WIDTH-1:0] act_q;
        logic [WIDTH-1:0] duty_nxt;
        logic             out_q;

        always_comb begin
            duty_nxt = (duty_wr && (duty_ch == CH_W'(i))) ? duty_in : pend_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q <= '0;
                act_q  <= '0;
                out_q  <= 1'b0;
            end else begin
                pend_q <= duty_nxt;
                if (boundary)
                    act_q <= duty_nxt;
                out_q <= en && (cnt < act_q);
            end
        end

        assign pwm[i] = out_q;
    end

endmodule
